// File: rtl/var_mem_pkg.sv
// Shared encodings for the variable-assignment store: truth values, commands and sweep states.
package var_mem_pkg;

  localparam logic [1:0] VAL_UNASG = 2'b00;
  localparam logic [1:0] VAL_FALSE = 2'b01;
  localparam logic [1:0] VAL_TRUE  = 2'b10;

  typedef enum logic [1:0] {
    CMD_READ      = 2'b00,
    CMD_ASSIGN    = 2'b01,
    CMD_UNASSIGN  = 2'b10,
    CMD_BACKTRACK = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_DONE  = 2'b10
  } sweep_state_e;

  // The unused code 2'b11 is folded to unassigned so stored values are always legal.
  function automatic logic [1:0] norm_val(input logic [1:0] v);
    return (v == 2'b11) ? VAL_UNASG : v;
  endfunction

  function automatic logic is_assigned(input logic [1:0] v);
    return v != VAL_UNASG;
  endfunction

endpackage

// File: rtl/var_mem_sweep_ctrl.sv
// Backtrack sweep sequencer: walks every entry once, then flags completion for one cycle.
module var_mem_sweep_ctrl
  import var_mem_pkg::*;
#(
  parameter int VAR_ADDR_W = 3,
  parameter int LEVEL_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEVEL_W-1:0]    target_in,
  output sweep_state_e          state,
  output logic [VAR_ADDR_W-1:0] ptr,
  output logic [LEVEL_W-1:0]    target,
  output logic                  mem_work,
  output logic                  bt_done
);

  localparam logic [VAR_ADDR_W-1:0] LAST = '1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      target   <= '0;
      mem_work <= 1'b0;
      bt_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bt_done <= 1'b0;
          if (start) begin
            state    <= ST_SWEEP;
            ptr      <= '0;
            target   <= target_in;
            mem_work <= 1'b1;
          end
        end
        ST_SWEEP: begin
          ptr <= ptr + 1'b1;
          if (ptr == LAST) begin
            state    <= ST_DONE;
            mem_work <= 1'b0;
            bt_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          // A command arriving in the completion cycle is served, including a new backtrack.
          bt_done <= 1'b0;
          if (start) begin
            state    <= ST_SWEEP;
            ptr      <= '0;
            target   <= target_in;
            mem_work <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          mem_work <= 1'b0;
          bt_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/var_assign_mem.sv
// Per-variable truth value / decision level store with live assigned count and backtrack sweep.
// Optional conflict detection is built when VAR_MEM_CONFLICT_EN is defined.
module var_assign_mem
  import var_mem_pkg::*;
#(
  parameter int VAR_ADDR_W = 3,
  parameter int LEVEL_W    = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_request,
  input  logic [1:0]            cmd,
  input  logic [VAR_ADDR_W-1:0] address,
  input  logic [1:0]            d_in,
  input  logic [LEVEL_W-1:0]    lvl_in,
  output logic [1:0]            d_out,
  output logic [LEVEL_W-1:0]    lvl_out,
  output logic                  d_valid,
  output logic                  mem_work,
  output logic                  bt_done,
  output logic [VAR_ADDR_W:0]   assigned_cnt,
  output logic                  all_assigned
`ifdef VAR_MEM_CONFLICT_EN
  ,
  output logic                  conflict
`endif
);

  localparam int DEPTH = 2 ** VAR_ADDR_W;
  localparam int CNT_W = VAR_ADDR_W + 1;

  // Handshake: a command is taken on a rising edge when mem_request=1, mem_work=0 and the
  // sweep FSM is IDLE or DONE; otherwise the request is dropped with no response.

  logic [1:0]         val_mem [DEPTH];
  logic [LEVEL_W-1:0] lvl_mem [DEPTH];

  sweep_state_e          state;
  logic [VAR_ADDR_W-1:0] ptr;
  logic [LEVEL_W-1:0]    target;

  logic       accept;
  logic       do_read;
  logic       do_assign;
  logic       do_unasg;
  logic       do_bt;
  logic [1:0] old_val;
  logic [1:0] new_val;
  logic       conflict_hit;
  logic       assign_wr;
  logic       sweep_clear;
  logic       cnt_inc;
  logic       cnt_dec;

  assign accept    = mem_request && !mem_work && (state == ST_IDLE || state == ST_DONE);
  assign do_read   = accept && (cmd == CMD_READ);
  assign do_assign = accept && (cmd == CMD_ASSIGN);
  assign do_unasg  = accept && (cmd == CMD_UNASSIGN);
  assign do_bt     = accept && (cmd == CMD_BACKTRACK);

  assign old_val      = val_mem[address];
  assign new_val      = norm_val(d_in);
  assign conflict_hit = is_assigned(old_val) && is_assigned(new_val) && (new_val != old_val);

`ifdef VAR_MEM_CONFLICT_EN
  assign assign_wr = do_assign && !conflict_hit;
`else
  assign assign_wr = do_assign;
`endif

  assign sweep_clear = (state == ST_SWEEP) && (lvl_mem[ptr] > target);

  // Sweeps and commands never overlap, so at most one of inc/dec is set per cycle.
  always_comb begin
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    if (sweep_clear) begin
      cnt_dec = is_assigned(val_mem[ptr]);
    end else if (assign_wr) begin
      cnt_inc = !is_assigned(old_val) && is_assigned(new_val);
      cnt_dec = is_assigned(old_val) && !is_assigned(new_val);
    end else if (do_unasg) begin
      cnt_dec = is_assigned(old_val);
    end
  end

  var_mem_sweep_ctrl #(
    .VAR_ADDR_W (VAR_ADDR_W),
    .LEVEL_W    (LEVEL_W)
  ) u_sweep (
    .clock     (clock),
    .reset     (reset),
    .start     (do_bt),
    .target_in (lvl_in),
    .state     (state),
    .ptr       (ptr),
    .target    (target),
    .mem_work  (mem_work),
    .bt_done   (bt_done)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        val_mem[i] <= VAL_UNASG;
        lvl_mem[i] <= '0;
      end
    end else if (sweep_clear) begin
      val_mem[ptr] <= VAL_UNASG;
      lvl_mem[ptr] <= '0;
    end else if (assign_wr) begin
      val_mem[address] <= new_val;
      lvl_mem[address] <= lvl_in;
    end else if (do_unasg) begin
      val_mem[address] <= VAL_UNASG;
      lvl_mem[address] <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_out        <= VAL_UNASG;
      lvl_out      <= '0;
      d_valid      <= 1'b0;
      assigned_cnt <= '0;
    end else begin
      d_valid <= do_read;
      if (do_read) begin
        d_out   <= old_val;
        lvl_out <= lvl_mem[address];
      end
      if (cnt_inc) begin
        assigned_cnt <= assigned_cnt + CNT_W'(1);
      end else if (cnt_dec) begin
        assigned_cnt <= assigned_cnt - CNT_W'(1);
      end
    end
  end

`ifdef VAR_MEM_CONFLICT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      conflict <= 1'b0;
    end else begin
      conflict <= do_assign && conflict_hit;
    end
  end
`endif

  assign all_assigned = (assigned_cnt == CNT_W'(DEPTH));

endmodule

// File: tb/tb_var_assign_mem.sv
// Directed bench for var_assign_mem: vector table for single-cycle commands, hand sequences for sweeps.
module tb_var_assign_mem;
  import var_mem_pkg::*;

  localparam int VAR_ADDR_W = 3;
  localparam int LEVEL_W    = 4;
  localparam int DEPTH      = 8;
  localparam int CNT_W      = 4;
  localparam int W          = 2 + LEVEL_W;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  mem_request = 1'b0;
  logic [1:0]            cmd = 2'b00;
  logic [VAR_ADDR_W-1:0] address = '0;
  logic [1:0]            d_in = 2'b00;
  logic [LEVEL_W-1:0]    lvl_in = '0;
  logic [1:0]            d_out;
  logic [LEVEL_W-1:0]    lvl_out;
  logic                  d_valid;
  logic                  mem_work;
  logic                  bt_done;
  logic [CNT_W-1:0]      assigned_cnt;
  logic                  all_assigned;
`ifdef VAR_MEM_CONFLICT_EN
  logic                  conflict;
`endif

  int checks = 0;
  int errors = 0;
  int cnt_range_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_item;

  typedef struct {
    logic [1:0]         cmd;
    logic [2:0]         addr;
    logic [1:0]         d;
    logic [LEVEL_W-1:0] lvl;
    logic [1:0]         exp_d;
    logic [LEVEL_W-1:0] exp_lvl;
    logic [CNT_W-1:0]   exp_cnt;
    logic               exp_conf;
  } vec_t;
  vec_t vecs[$];

  var_assign_mem #(
    .VAR_ADDR_W (VAR_ADDR_W),
    .LEVEL_W    (LEVEL_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_request  (mem_request),
    .cmd          (cmd),
    .address      (address),
    .d_in         (d_in),
    .lvl_in       (lvl_in),
    .d_out        (d_out),
    .lvl_out      (lvl_out),
    .d_valid      (d_valid),
    .mem_work     (mem_work),
    .bt_done      (bt_done),
    .assigned_cnt (assigned_cnt),
    .all_assigned (all_assigned)
`ifdef VAR_MEM_CONFLICT_EN
    ,
    .conflict     (conflict)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every d_valid pulse must match the oldest expected read
  always @(negedge clock) begin
    if (reset && (assigned_cnt > CNT_W'(DEPTH))) cnt_range_bad++;
    if (d_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_d_valid: got d_valid=1 d_out=%0h lvl_out=%0h, no read pending", d_out, lvl_out);
      end else begin
        exp_item = exp_q.pop_front();
        if ({d_out, lvl_out} !== exp_item) begin
          errors++;
          $display("FAIL read_data: got %0h expected %0h", {d_out, lvl_out}, exp_item);
        end
      end
    end
  end

  // drivers
  task automatic issue(input logic [1:0] c, input logic [2:0] a, input logic [1:0] d,
                       input logic [LEVEL_W-1:0] l);
    @(negedge clock);
    cmd = c; address = a; d_in = d; lvl_in = l; mem_request = 1'b1;
    @(posedge clock);
    #1;
    mem_request = 1'b0;
  endtask

  task automatic read_exp(input logic [2:0] a, input logic [1:0] ed, input logic [LEVEL_W-1:0] el);
    exp_q.push_back({ed, el});
    issue(CMD_READ, a, 2'b00, '0);
  endtask

  function automatic logic [1:0] pat_val(input int i);
    return (i % 2 == 1) ? VAL_TRUE : VAL_FALSE;
  endfunction

  initial begin
    int mw_cnt;
    int bd_cnt;
    int timing_bad;

    vecs.push_back('{CMD_READ,      3'd5, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd2, 2'b10, 4'd3, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_READ,      3'd2, 2'b00, 4'd0, 2'b10, 4'd3, 4'd1, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd2, 2'b10, 4'd4, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_READ,      3'd2, 2'b00, 4'd0, 2'b10, 4'd4, 4'd1, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd6, 2'b01, 4'd2, 2'b00, 4'd0, 4'd2, 1'b0});
    vecs.push_back('{CMD_UNASSIGN,  3'd6, 2'b00, 4'd0, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_UNASSIGN,  3'd6, 2'b00, 4'd0, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_READ,      3'd6, 2'b00, 4'd0, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd2, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});
    vecs.push_back('{CMD_READ,      3'd2, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd3, 2'b11, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});
    vecs.push_back('{CMD_READ,      3'd3, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd1, 2'b01, 4'd1, 2'b00, 4'd0, 4'd1, 1'b0});
    vecs.push_back('{CMD_ASSIGN,    3'd1, 2'b10, 4'd2, 2'b00, 4'd0, 4'd1, 1'b1});
`ifdef VAR_MEM_CONFLICT_EN
    vecs.push_back('{CMD_READ,      3'd1, 2'b00, 4'd0, 2'b01, 4'd1, 4'd1, 1'b0});
`else
    vecs.push_back('{CMD_READ,      3'd1, 2'b00, 4'd0, 2'b10, 4'd2, 4'd1, 1'b0});
`endif
    vecs.push_back('{CMD_UNASSIGN,  3'd1, 2'b00, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0});

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {d_out, lvl_out, d_valid, mem_work, bt_done, assigned_cnt, all_assigned}, 0);
    @(negedge clock);
    reset = 1'b1;

    // single-cycle command table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].cmd == CMD_READ) exp_q.push_back({vecs[i].exp_d, vecs[i].exp_lvl});
      issue(vecs[i].cmd, vecs[i].addr, vecs[i].d, vecs[i].lvl);
      check($sformatf("vec%0d_cnt", i), assigned_cnt, vecs[i].exp_cnt);
`ifdef VAR_MEM_CONFLICT_EN
      check($sformatf("vec%0d_conflict", i), conflict, vecs[i].exp_conf);
`endif
    end

    // fill every entry, address i at level i
    for (int i = 0; i < DEPTH; i++) issue(CMD_ASSIGN, 3'(i), pat_val(i), 4'(i));
    check("full_cnt", assigned_cnt, DEPTH);
    check("full_all_assigned", all_assigned, 1);
    read_exp(3'd3, VAL_TRUE, 4'd3);

    // backtrack to level 3 with a dropped read mid-sweep and a read in the bt_done cycle
    issue(CMD_BACKTRACK, 3'd0, 2'b00, 4'd3);
    mw_cnt = 0; bd_cnt = 0; timing_bad = 0;
    for (int c = 1; c <= DEPTH + 2; c++) begin
      if (mem_work) mw_cnt++;
      if (bt_done) bd_cnt++;
      if (mem_work !== (c <= DEPTH) || bt_done !== (c == DEPTH + 1)) timing_bad++;
      if (c == 2) begin
        cmd = CMD_READ; address = 3'd0; mem_request = 1'b1;
      end
      if (c == DEPTH + 1) begin
        exp_q.push_back({VAL_TRUE, 4'd1});
        cmd = CMD_READ; address = 3'd1; mem_request = 1'b1;
      end
      @(posedge clock);
      #1;
      mem_request = 1'b0;
    end
    check("bt_mem_work_cycles", mw_cnt, DEPTH);
    check("bt_done_pulses", bd_cnt, 1);
    check("bt_timing", timing_bad, 0);
    check("bt_cnt", assigned_cnt, 4);
    check("bt_all_assigned", all_assigned, 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= 3) read_exp(3'(i), pat_val(i), 4'(i));
      else read_exp(3'(i), VAL_UNASG, 4'd0);
    end

    // reset during sweep cycle 4
    read_exp(3'd3, VAL_TRUE, 4'd3);
    issue(CMD_BACKTRACK, 3'd0, 2'b00, 4'd0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    check("sweep4_mem_work", mem_work, 1);
    reset = 1'b0;
    #1;
    check("midreset_outputs", {d_out, lvl_out, d_valid, mem_work, bt_done, assigned_cnt, all_assigned}, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    mw_cnt = 0; bd_cnt = 0;
    for (int c = 0; c < DEPTH + 4; c++) begin
      @(posedge clock);
      #1;
      if (mem_work) mw_cnt++;
      if (bt_done) bd_cnt++;
    end
    check("midreset_no_bt_done", bd_cnt, 0);
    check("midreset_no_mem_work", mw_cnt, 0);
    for (int i = 0; i < DEPTH; i++) read_exp(3'(i), VAL_UNASG, 4'd0);
    check("midreset_cnt", assigned_cnt, 0);

    @(negedge clock);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    check("cnt_range", cnt_range_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/var_assign_mem.md
Name: var_assign_mem

Overview:
- Parametrised variable-assignment store for the hardware BCP engine.
- Holds one 2-bit truth value and one decision level per SAT variable.
- Serves single-cycle read, assign and unassign commands from the BCP controller.
- Adds a multi-cycle backtrack sweep that un-assigns every variable above a target decision level, and keeps a live count of assigned variables.

Parameters:
- VAR_ADDR_W, 3: variable index width; DEPTH = 2**VAR_ADDR_W entries.
- LEVEL_W, 4: decision-level width.
- CNT_W, VAR_ADDR_W+1: assigned-count width (derived; not overridden).

Ports:
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- mem_request, input, 1: command strobe; accepted only when mem_work=0.
- cmd, input, 2: 00 READ, 01 ASSIGN, 10 UNASSIGN, 11 BACKTRACK.
- address, input, VAR_ADDR_W: variable index (ignored for BACKTRACK).
- d_in, input, 2: value for ASSIGN; 00 unassigned, 01 false, 10 true; 11 is illegal and treated as 00.
- lvl_in, input, LEVEL_W: level for ASSIGN; target level for BACKTRACK.
- d_out, output, 2: read value.
- lvl_out, output, LEVEL_W: read level.
- d_valid, output, 1: one-cycle pulse; d_out/lvl_out are valid.
- mem_work, output, 1: high while a backtrack sweep is running.
- bt_done, output, 1: one-cycle pulse when a sweep completes.
- assigned_cnt, output, CNT_W: number of entries not unassigned.
- all_assigned, output, 1: assigned_cnt == DEPTH (combinational from the counter).
- conflict, output, 1: present only with the optional feature.

Behaviour:
- Reset (async, reset=0):
  - All entries become value 00, level 0.
  - d_out=0, lvl_out=0, d_valid=0, mem_work=0, bt_done=0, assigned_cnt=0, conflict=0.
  - FSM goes to IDLE.
  - Reset mid-sweep aborts the sweep; no bt_done is produced.
- Accept: a command is accepted on a rising edge with mem_request=1, mem_work=0 and FSM in IDLE or DONE. Requests at any other time are dropped silently.
- READ: d_out/lvl_out are registered at the accept edge; d_valid is high for the following cycle (latency 1). Reading an address being written in the same cycle returns the old contents.
- ASSIGN:
  - The entry is written at the accept edge.
  - If the old value was 00 and the new value is not 00, assigned_cnt increments.
  - If the old value was assigned and the new value is 00, assigned_cnt decrements.
  - Otherwise assigned_cnt is unchanged (overwrite).
- UNASSIGN: the entry is set to value 00, level 0. assigned_cnt decrements only if the entry was assigned; otherwise the command is a no-op.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on an accepted BACKTRACK; the target level is latched and the sweep pointer is set to 0.
  - SWEEP:
    - mem_work=1.
    - Each cycle, the entry at the pointer is cleared if its level > target.
    - assigned_cnt decrements for each cleared assigned entry.
    - The pointer increments.
    - After entry DEPTH-1, go to DONE.
  - DONE: bt_done=1 and mem_work=0 for one cycle, then IDLE. A new command is accepted in DONE.
- Timing: BACKTRACK accepted at edge T -> mem_work high for cycles T+1..T+DEPTH, bt_done high in cycle T+DEPTH+1.
- Entries with level <= target, including level 0, are preserved.
- BACKTRACK with target >= max level is a full sweep with no changes.
- The pointer wraps from DEPTH-1 to 0 naturally; it is only used in SWEEP.
- assigned_cnt never underflows or overflows by construction. Assertions in the bench check 0..DEPTH.

Optional Feature:
- Macro: VAR_MEM_CONFLICT_EN.
- Enabled: the conflict port exists. An ASSIGN whose d_in is the opposite non-zero value of an already-assigned entry does not write and does not change the count. conflict pulses high the cycle after acceptance.
- Disabled: no conflict port; such an ASSIGN overwrites the entry and the count is unchanged.

Decomposition:
- Package var_mem_pkg holds:
  - Value constants VAL_UNASG=2'b00, VAL_FALSE=2'b01, VAL_TRUE=2'b10.
  - Command encodings CMD_READ/ASSIGN/UNASSIGN/BACKTRACK.
  - Sweep state encodings.
- One sub-module, var_mem_sweep_ctrl: the FSM, sweep pointer, latched target level, and the mem_work/bt_done generation.
- The storage array and counter stay in the top module.

Test Plan:
- Reset, then READ of addr 5 -> d_valid pulses one cycle later with d_out=00, lvl_out=0; assigned_cnt=0.
- ASSIGN addr 2 = 10 @ level 3, then READ addr 2 -> d_out=10, lvl_out=3, assigned_cnt=1. Re-ASSIGN addr 2 = 10 @ level 4 -> assigned_cnt remains 1.
- Assign all 8 entries with levels 0..7, then BACKTRACK target 3:
  - mem_work is high exactly 8 cycles; bt_done pulses once.
  - Addresses with level 4..7 read 00; assigned_cnt=4; all_assigned went 1 -> 0.
- mem_request READ issued during SWEEP -> no d_valid, memory unchanged. A command in the bt_done cycle is accepted.
- Assert reset at sweep cycle 4 -> all outputs 0, no bt_done, all entries read 00 after reset.
- With VAR_MEM_CONFLICT_EN: addr 1 = 01, then ASSIGN addr 1 = 10 -> conflict pulses, READ returns 01, count unchanged. Without the macro -> READ returns 10.
